pipe_ctrl: RTL

Pipeline control unit for the 5-stage WISC pipeline (IF/ID/EX/MEM/WB). It sits beside the ID-stage instruction decoder and consumes the decoder's register-read, write, memory and halt outputs. It generates stall and flush controls for the IF/ID and ID/EX pipeline registers to handle three cases: load-use hazards, taken-branch squashes, and the halt drain sequence. All other data hazards are resolved by forwarding elsewhere; this block never stalls for them.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_ld_use_det.sv | 41 ++++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings, widths and helpers for the WISC pipeline control unit.
// Latency: none (types only); backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int PC_STATE_W = 2;
    localparam int PC_CNT_W   = 4;
    localparam int REG_ADDR_W = 4;
    localparam int PC_PERF_W  = 16;

    typedef enum logic [PC_STATE_W-1:0] {
        PC_RUN    = 2'd0,
        PC_DRAIN  = 2'd1,
        PC_HALTED = 2'd2
    } pc_state_t;

    function automatic logic [PC_PERF_W-1:0] sat_inc(input logic [PC_PERF_W-1:0] v);
        return (v == {PC_PERF_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_ld_use_det.sv
// Tracks whether EX holds a load and flags a load-use hazard against the ID read ports.
// Latency: hazard is combinational; EX tracking updates each edge. Backpressure: none.
module ld_use_det
    import pipe_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bubble,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_p0_addr,
    input  logic                  id_re0,
    input  logic [REG_ADDR_W-1:0] id_p1_addr,
    input  logic                  id_re1,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_mem_rd,
    output logic                  lu
);

    logic                  ex_ld_vld;
    logic [REG_ADDR_W-1:0] ex_ld_dst;
    logic                  hit0;
    logic                  hit1;

    // Every stall also injects a bubble, so "no bubble" means the ID instruction moved into EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ld_vld <= 1'b0;
            ex_ld_dst <= '0;
        end else if (bubble) begin
            ex_ld_vld <= 1'b0;
        end else begin
            ex_ld_vld <= id_valid & id_mem_rd;
            ex_ld_dst <= id_dst_addr;
        end
    end

    assign hit0 = id_re0 && (id_p0_addr == ex_ld_dst);
    assign hit1 = id_re1 && (id_p1_addr == ex_ld_dst);
    assign lu   = id_valid && ex_ld_vld && (ex_ld_dst != '0) && (hit0 || hit1);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush control for IF/ID and ID/EX: load-use stall, taken-branch squash, HLT drain; PIPE_CTRL_PERF_EN adds event counters.
// Latency: stall/flush combinational same cycle, halted registered; backpressure: stall_if/stall_id hold upstream stages.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_p0_addr,
    input  logic                  id_re0,
    input  logic [REG_ADDR_W-1:0] id_p1_addr,
    input  logic                  id_re1,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_memRd,
    input  logic                  id_hlt,
    input  logic                  ex_br_taken,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  flush_ex,
`ifdef PIPE_CTRL_PERF_EN
    output logic [PC_PERF_W-1:0]  perf_stall_cnt,
    output logic [PC_PERF_W-1:0]  perf_flush_cnt,
`endif
    output logic                  halted
);

    localparam logic [PC_CNT_W-1:0] DRAIN_INIT = PC_CNT_W'(DRAIN_CYCLES - 1);

    pc_state_t           state;
    logic [PC_CNT_W-1:0] drain_cnt;
    logic                lu;
    logic                hlt_accept;

    ld_use_det u_ld_use_det (
        .clk         (clk),
        .rst         (rst),
        .bubble      (flush_ex),
        .id_valid    (id_valid),
        .id_p0_addr  (id_p0_addr),
        .id_re0      (id_re0),
        .id_p1_addr  (id_p1_addr),
        .id_re1      (id_re1),
        .id_dst_addr (id_dst_addr),
        .id_mem_rd   (id_memRd),
        .lu          (lu)
    );

    assign hlt_accept = (state == PC_RUN) && !ex_br_taken && !lu && id_valid && id_hlt;

    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        case (state)
            PC_RUN: begin
                if (ex_br_taken) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (lu) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (id_valid && id_hlt) begin
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                end
            end
            // Nothing younger than HLT is real, so a branch during drain is irrelevant.
            PC_DRAIN: begin
                stall_if = 1'b1;
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end
            PC_HALTED: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PC_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            case (state)
                PC_RUN: begin
                    if (hlt_accept) begin
                        state     <= PC_DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                PC_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= PC_HALTED;
                        halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                PC_HALTED: halted <= 1'b1;
                default: begin
                    state  <= PC_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (state == PC_RUN) begin
            if (ex_br_taken) begin
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
            end else if (lu) begin
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            end
        end
    end
`endif

endmodule
